// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte plus odd parity
// and stop bit on device-generated clocks, then checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned CLK_INHIBIT_CYCLES = 6000,
  parameter int unsigned DATA_SETUP_CYCLES  = 250,
  parameter int unsigned TIMEOUT_CYCLES     = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MaxAb     = (CLK_INHIBIT_CYCLES > DATA_SETUP_CYCLES) ?
                                      CLK_INHIBIT_CYCLES : DATA_SETUP_CYCLES;
  localparam int unsigned MaxCycles = (MaxAb > TIMEOUT_CYCLES) ? MaxAb : TIMEOUT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] InhibitLast = CntW'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] SetupLast   = CntW'(DATA_SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StSend,
    StAck,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bitn_q, bitn_d;
  logic [8:0]      shift_q, shift_d;
  logic            txbit_q, txbit_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_prev_q;
  logic            clk_s, dat_s, clk_fall;

  // Pins are asynchronous; synchronizers idle high like the released bus.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_s;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      txbit_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      txbit_q <= txbit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bitn_d  = bitn_q;
    shift_d = shift_q;
    txbit_d = txbit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        bitn_d = '0;
        // The cycle a done/err pulse is visible is still part of the finished transfer.
        if (send && !done_q && !err_q) begin
          shift_d = {~^tx_byte, tx_byte};
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          bitn_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (bitn_q == 4'd9) begin
            state_d = StAck;
          end else begin
            txbit_d = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bitn_d  = bitn_q + 4'd1;
          end
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StAck: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (dat_s) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWaitIdle;
          end
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitIdle: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Before the first device edge in StSend the start bit (low) is still held.
  always_comb begin
    ps2_clk_oe = (state_q == StInhibit) || (state_q == StStart);
    ps2_dat_oe = (state_q == StStart) ||
                 ((state_q == StSend) && ((bitn_q == 4'd0) || !txbit_q));
    busy       = (state_q != StIdle);
    done       = done_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and
// the received bits, handshake pulses and phase lengths are compared to a frame model.
module tb_ps2_host_tx;

  localparam int unsigned Inh    = 60;
  localparam int unsigned Setup  = 25;
  localparam int unsigned Tmo    = 2000;
  localparam int unsigned Half   = 20;
  localparam int unsigned LeadIn = 30;

  localparam int ModeAckLow  = 0;
  localparam int ModeAckHigh = 1;
  localparam int ModeSilent  = 2;
  localparam int ModeReset   = 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] tx_byte;
  logic       PS2_CLK, PS2_DAT;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;
  logic       dev_clk, dev_dat_low;

  int n_checks = 0;
  int n_errors = 0;

  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   inh_cyc = 0, setup_cyc = 0, rel_cnt = 0, err_rel = -1;
  logic prev_clk_oe = 1'b0;
  int   got_bits [10];

  // Open-collector bus: low if either side pulls.
  assign PS2_CLK = ps2_clk_oe ? 1'b0 : dev_clk;
  assign PS2_DAT = (ps2_dat_oe || dev_dat_low) ? 1'b0 : 1'b1;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .CLK_INHIBIT_CYCLES(Inh),
    .DATA_SETUP_CYCLES (Setup),
    .TIMEOUT_CYCLES    (Tmo)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .send      (send),
    .tx_byte   (tx_byte),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(negedge CLOCK_50) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (ps2_clk_oe && !ps2_dat_oe) inh_cyc++;
    if (ps2_clk_oe && ps2_dat_oe) setup_cyc++;
    if (prev_clk_oe && !ps2_clk_oe) rel_cnt = 0;
    else rel_cnt++;
    if (err) err_rel = rel_cnt;
    prev_clk_oe = ps2_clk_oe;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Frame position k: 0..7 data LSB first, 8 odd parity, 9 stop.
  function automatic int exp_bit(input logic [7:0] b, input int k);
    int ones;
    ones = 0;
    if (k < 8) return (int'(b) >> k) % 2;
    if (k == 9) return 1;
    for (int i = 0; i < 8; i++) ones += (int'(b) >> i) % 2;
    return (ones % 2 == 0) ? 1 : 0;
  endfunction

  task automatic run_xfer(input logic [7:0] b, input int mode, input bit send_again);
    int d0, e0, i0, s0, t;
    bit seen, rel, fin;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cyc; s0 = setup_cyc;
    @(negedge CLOCK_50);
    send = 1'b1; tx_byte = b; t = 0;
    @(negedge CLOCK_50);
    send = 1'b0; tx_byte = 8'($urandom); t = 1;
    seen = 1'b0; rel = 1'b0;
    for (int i = 0; i < 500 && !rel; i++) begin
      if (ps2_clk_oe) seen = 1'b1;
      else if (seen) rel = 1'b1;
      if (!rel) begin
        @(negedge CLOCK_50);
        t++;
      end
    end
    check_eq("clk_release", int'(rel), 1);
    for (int i = 0; i < int'(LeadIn); i++) begin
      @(negedge CLOCK_50);
      t++;
      send = send_again && (t == 100);
      if (send) tx_byte = 8'h55;
    end
    send = 1'b0;

    if (mode == ModeSilent) begin
      for (int i = 0; i < int'(Tmo) + 100 && err_cnt == e0; i++) @(negedge CLOCK_50);
      repeat (10) @(negedge CLOCK_50);
      check_eq("timeout_at", err_rel, int'(Tmo));
      check_eq("timeout_err", err_cnt - e0, 1);
      check_eq("timeout_done", done_cnt - d0, 0);
      check_eq("timeout_clk_oe", int'(ps2_clk_oe), 0);
      check_eq("timeout_dat_oe", int'(ps2_dat_oe), 0);
    end else begin
      for (int k = 1; k <= 11; k++) begin
        if (k == 11) dev_dat_low = (mode == ModeAckLow);
        dev_clk = 1'b0;
        repeat (Half) @(negedge CLOCK_50);
        if (mode == ModeReset) begin
          check_eq("pre_reset_dat_oe", int'(ps2_dat_oe), 1);
          reset = 1'b0;
          @(negedge CLOCK_50);
          check_eq("reset_clk_oe", int'(ps2_clk_oe), 0);
          check_eq("reset_dat_oe", int'(ps2_dat_oe), 0);
          check_eq("reset_busy", int'(busy), 0);
          repeat (4) @(negedge CLOCK_50);
          reset = 1'b1;
          dev_clk = 1'b1;
          repeat (20) @(negedge CLOCK_50);
          check_eq("reset_no_done", done_cnt - d0, 0);
          check_eq("reset_no_err", err_cnt - e0, 0);
          check_eq("reset_idle_busy", int'(busy), 0);
          return;
        end
        if (k <= 10) got_bits[k-1] = int'(PS2_DAT);
        dev_clk = 1'b1;
        repeat (Half) @(negedge CLOCK_50);
      end
      repeat (5) @(negedge CLOCK_50);
      dev_dat_low = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 200 && !fin; i++) begin
        @(negedge CLOCK_50);
        fin = (done_cnt != d0) || (err_cnt != e0);
      end
      repeat (10) @(negedge CLOCK_50);
      for (int k = 0; k < 10; k++) begin
        check_eq($sformatf("bit%0d_of_%02h", k, b), got_bits[k], exp_bit(b, k));
      end
      check_eq("done_count", done_cnt - d0, (mode == ModeAckLow) ? 1 : 0);
      check_eq("err_count", err_cnt - e0, (mode == ModeAckHigh) ? 1 : 0);
      check_eq("end_dat_oe", int'(ps2_dat_oe), 0);
    end
    check_eq("end_busy", int'(busy), 0);
    check_eq("end_clk_oe", int'(ps2_clk_oe), 0);
    // A second accepted send would add another inhibit phase.
    check_eq("inhibit_cycles", inh_cyc - i0, int'(Inh));
    check_eq("setup_cycles", setup_cyc - s0, int'(Setup));
  endtask

  initial begin
    reset = 1'b0; send = 1'b0; tx_byte = 8'h00;
    dev_clk = 1'b1; dev_dat_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_clk_oe", int'(ps2_clk_oe), 0);
    check_eq("rst_dat_oe", int'(ps2_dat_oe), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    run_xfer(8'hED, ModeAckLow, 1'b0);
    run_xfer(8'hF4, ModeAckLow, 1'b0);
    run_xfer(8'hED, ModeAckLow, 1'b1);
    run_xfer(8'h00, ModeAckHigh, 1'b0);
    run_xfer(8'hA5, ModeSilent, 1'b0);
    run_xfer(8'h00, ModeReset, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_xfer(8'($urandom), ($urandom_range(0, 3) == 0) ? ModeAckHigh : ModeAckLow, 1'b0);
    end
    run_xfer(8'h3C, ModeAckLow, 1'b0);

    check_eq("done_err_overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) followed by an LED mask, or 0xF4 (enable scanning).
- It is the outbound counterpart of the existing keyboard receive path and shares the same PS2_CLK and PS2_DAT pins.
- Pins are open-collector. This block only asserts pull-low enables. The top level does the tristate: pin = oe ? 1'b0 : 1'bz, and feeds the pin values back in.

Parameters:
- CLK_INHIBIT_CYCLES, 6000, CLOCK_50 cycles the host holds clock low before the start bit (120 us; PS/2 requires at least 100 us).
- DATA_SETUP_CYCLES, 250, cycles data is held low with clock still low before clock is released (5 us).
- TIMEOUT_CYCLES, 750000, maximum cycles to wait for any expected device clock edge or line release (15 ms).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-low reset.
- send  input  1  one-cycle request; accepted only when busy=0.
- tx_byte  input  8  byte to send; captured on the cycle send is accepted.
- PS2_CLK  input  1  clock pin readback (asynchronous).
- PS2_DAT  input  1  data pin readback (asynchronous).
- ps2_clk_oe  output  1  1 = drive PS2_CLK low.
- ps2_dat_oe  output  1  1 = drive PS2_DAT low.
- busy  output  1  high from the accepted send until return to IDLE.
- done  output  1  one-cycle pulse: byte sent and device ACKed.
- err  output  1  one-cycle pulse: timeout, or ACK bit sampled high.

Behaviour:
- Reset (reset=0 sampled on a CLOCK_50 edge) forces:
  - ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, err=0.
  - State IDLE, all counters cleared, synchronizers preset to 1.
  - This applies mid-transfer too: lines are released on the next edge.
- Input conditioning:
  - PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer.
  - A falling-edge strobe is generated from the synced clock (previous=1, current=0).
  - Edge latency is 3 cycles from the pin.
- Shift register is 9 bits: {parity, tx_byte}, sent LSB first. Parity is odd: parity = ~^tx_byte.
- State machine:
  - IDLE: outputs released. When send=1, capture the shift register, set busy=1 the next cycle, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for CLK_INHIBIT_CYCLES cycles, then go to START.
  - START: ps2_clk_oe=1, ps2_dat_oe=1 (start bit 0) for DATA_SETUP_CYCLES cycles, then go to SEND.
  - SEND: ps2_clk_oe=0; bit counter n=0; timeout counter running.
    - Falling edges 1 to 9: drive data with bit n, where ps2_dat_oe = ~bit. Increment n.
    - Falling edge 10: ps2_dat_oe=0 (stop bit 1), then go to ACK.
  - ACK: on the next falling edge (the 11th), sample synced data.
    - 0: go to WAIT_IDLE.
    - 1: pulse err, go to IDLE.
  - WAIT_IDLE: wait until synced clock=1 and synced data=1, then pulse done and go to IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, the counter resets on every falling edge. If it reaches TIMEOUT_CYCLES, both oe signals drop to 0, err pulses, and the state returns to IDLE.
- busy drops in the same cycle that done or err is pulsed. done and err are never high together.
- send while busy=1 is ignored; no queueing. tx_byte is not sampled after acceptance.
- Simultaneous send and reset: reset wins.
- send in the same cycle as done/err: ignored. The next send is accepted in the following IDLE cycle.
- A glitch in device clock before START completes has no effect. Falling edges are only counted in SEND and ACK.
- The keyboard receive path must gate on busy: device clocks during a transmission are not scancodes.

Test Plan:
- Reset: hold reset=0 for 5 cycles mid-SEND. Required: both oe=0 and busy=0 on the next edge, and no done/err.
- Send 0xED, device model clocking at 12.5 kHz with ACK=0.
  - ps2_clk_oe high for exactly 6000 cycles, then dat low 250 cycles before clock release.
  - Sampled data bits after falling edges 1 to 9: 1,0,1,1,0,1,1,1, parity 1.
  - done pulses once, busy low afterward.
- Send 0xF4: bits 0,0,1,0,1,1,1,1, parity 0; then done.
- Device never clocks after START: err pulses exactly 750000 cycles after clock release, all lines released.
- ACK sampled high on edge 11 with tx_byte 0x00: parity bit 1 observed, then err pulses and done stays 0.
- send pulsed again at cycle 100 of a transfer with tx_byte 0x55: the in-flight 0xED frame is unchanged, and only one done is produced.
